// File: rtl/cci_mpf_c0_rd_req_buffer.sv
// Channel-0 read-request staging buffer: absorbs AFU read requests in a FIFO and
// releases them to the QLP under QLP almost-full and an outstanding-read limit.
module cci_mpf_c0_rd_req_buffer #(
    parameter int CCI_TX_HDR_WIDTH = 61,
    parameter int DEPTH            = 16,
    parameter int ALMFULL_SLACK    = 4,
    parameter int MAX_OUTSTANDING  = 128,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CCI_TX_HDR_WIDTH-1:0] afu_C0TxHdr,
    input  logic                        afu_C0TxRdValid,
    output logic                        afu_C0TxAlmFull,
    output logic [CCI_TX_HDR_WIDTH-1:0] qlp_C0TxHdr,
    output logic                        qlp_C0TxRdValid,
    input  logic                        qlp_C0TxAlmFull,
    input  logic                        qlp_C0RxRdValid,
    output logic [OUT_W-1:0]            outstanding,
    output logic                        err_overflow,
    output logic                        err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CCI_TX_HDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [OUT_W-1:0]            outstanding_q, outstanding_d;
    logic [CCI_TX_HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic                        valid_q, valid_d;
    logic                        almfull_q, almfull_d;
    logic                        err_ovf_q, err_ovf_d;
    logic                        err_unf_q, err_unf_d;
    logic                        full_s, empty_s, room_s;
    logic                        push_s, pop_s, ovf_s, unf_s;

    // Pop/push decisions from registered state plus same-cycle QLP inputs.
    always_comb begin
        full_s  = (count_q == CNT_W'(DEPTH));
        empty_s = (count_q == CNT_W'(0));
        room_s  = (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        pop_s   = !empty_s && !qlp_C0TxAlmFull && (room_s || qlp_C0RxRdValid);
        // A push into a full FIFO is only legal when the head leaves the same cycle.
        push_s  = afu_C0TxRdValid && (!full_s || pop_s);
        ovf_s   = afu_C0TxRdValid && full_s && !pop_s;
    end

    // Next-state computation for FIFO bookkeeping, output register and counters.
    always_comb begin
        count_d       = count_q;
        outstanding_d = outstanding_q;
        unf_s         = 1'b0;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({pop_s, qlp_C0RxRdValid})
            2'b10: outstanding_d = outstanding_q + OUT_W'(1);
            2'b01: begin
                if (outstanding_q == OUT_W'(0)) begin
                    unf_s         = 1'b1;
                    outstanding_d = outstanding_q;
                end else begin
                    outstanding_d = outstanding_q - OUT_W'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            hdr_d    = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            hdr_d    = hdr_q;
        end
        valid_d   = pop_s;
        almfull_d = (count_d >= CNT_W'(DEPTH - ALMFULL_SLACK));
        err_ovf_d = err_ovf_q | ovf_s;
        err_unf_d = err_unf_q | unf_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            hdr_q         <= '0;
            valid_q       <= 1'b0;
            almfull_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            hdr_q         <= hdr_d;
            valid_q       <= valid_d;
            almfull_q     <= almfull_d;
            err_ovf_q     <= err_ovf_d;
            err_unf_q     <= err_unf_d;
        end
    end

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= afu_C0TxHdr;
        end
    end

    // Held high during reset so the AFU stays quiet; registered occupancy otherwise.
    assign afu_C0TxAlmFull = almfull_q | reset;
    assign qlp_C0TxHdr     = hdr_q;
    assign qlp_C0TxRdValid = valid_q;
    assign outstanding     = outstanding_q;
    assign err_overflow    = err_ovf_q;
    assign err_underflow   = err_unf_q;

endmodule

// File: tb/tb_cci_mpf_c0_rd_req_buffer.sv
// Self-checking bench: directed table, corner-case sequences and random traffic
// compared against a queue-based reference model.
module tb_cci_mpf_c0_rd_req_buffer;

    localparam int HW    = 61;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;
    localparam int MAXO  = 4;
    localparam int OW    = $clog2(MAXO + 1);

    logic          clk;
    logic          reset;
    logic [HW-1:0] afu_hdr;
    logic          afu_v;
    logic          afu_alm;
    logic [HW-1:0] qlp_hdr;
    logic          qlp_v;
    logic          qlp_alm;
    logic          qlp_rx;
    logic [OW-1:0] outs;
    logic          e_ovf;
    logic          e_unf;

    int tests;
    int failed;

    cci_mpf_c0_rd_req_buffer #(
        .CCI_TX_HDR_WIDTH(HW), .DEPTH(DEPTH), .ALMFULL_SLACK(SLACK), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .afu_C0TxHdr(afu_hdr), .afu_C0TxRdValid(afu_v), .afu_C0TxAlmFull(afu_alm),
        .qlp_C0TxHdr(qlp_hdr), .qlp_C0TxRdValid(qlp_v), .qlp_C0TxAlmFull(qlp_alm),
        .qlp_C0RxRdValid(qlp_rx), .outstanding(outs),
        .err_overflow(e_ovf), .err_underflow(e_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending requests as a queue, counts as integers.
    logic [HW-1:0] mq[$];
    int            m_out;
    logic          m_valid;
    logic [HW-1:0] m_hdr;
    logic          m_alm;
    logic          m_ovf;
    logic          m_unf;
    logic          m_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic p, input logic [HW-1:0] h,
                                input logic qa, input logic rx, input logic rs);
        bit pop;
        bit was_full;
        m_rst = rs;
        if (rs) begin
            mq.delete();
            m_out = 0; m_valid = 1'b0; m_hdr = '0; m_alm = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop = (mq.size() > 0) && !qa && ((m_out < MAXO) || rx);
            m_valid = pop;
            if (pop) m_hdr = mq.pop_front();
            if (p) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else mq.push_back(h);
            end
            if (pop && !rx) m_out++;
            else if (!pop && rx) begin
                if (m_out == 0) m_unf = 1'b1;
                else m_out--;
            end
            m_alm = (mq.size() >= DEPTH - SLACK);
        end
    endtask

    // One clock: drive at the falling edge, compare after the next falling edge.
    task automatic step(input logic p, input logic [HW-1:0] h, input logic qa,
                        input logic rx, input logic rs);
        afu_v = p; afu_hdr = h; qlp_alm = qa; qlp_rx = rx; reset = rs;
        model_update(p, h, qa, rx, rs);
        @(posedge clk);
        @(negedge clk);
        chk("valid", 64'(qlp_v), 64'(m_valid));
        chk("hdr", 64'(qlp_hdr), 64'(m_hdr));
        chk("outstanding", 64'(outs), 64'(m_out));
        chk("afu_almfull", 64'(afu_alm), 64'(m_rst ? 1'b1 : m_alm));
        chk("err_overflow", 64'(e_ovf), 64'(m_ovf));
        chk("err_underflow", 64'(e_unf), 64'(m_unf));
    endtask

    task automatic idle(input logic qa, input logic rx);
        step(1'b0, '0, qa, rx, 1'b0);
    endtask

    typedef struct {
        logic          push;
        logic [HW-1:0] hdr;
        logic          qa;
        logic          rx;
        logic          ev;
        logic [HW-1:0] eh;
        int            eo;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int nv;
        tests = 0; failed = 0;
        afu_v = 1'b0; afu_hdr = '0; qlp_alm = 1'b0; qlp_rx = 1'b0; reset = 1'b1;

        tbl[0] = '{1'b1, 61'h1A5, 1'b0, 1'b0, 1'b0, 61'h0,   0};
        tbl[1] = '{1'b0, 61'h0,   1'b0, 1'b0, 1'b1, 61'h1A5, 1};
        tbl[2] = '{1'b0, 61'h0,   1'b0, 1'b0, 1'b0, 61'h1A5, 1};
        tbl[3] = '{1'b0, 61'h0,   1'b0, 1'b1, 1'b0, 61'h1A5, 0};
        tbl[4] = '{1'b1, 61'h2B,  1'b0, 1'b0, 1'b0, 61'h1A5, 0};
        tbl[5] = '{1'b1, 61'h3C,  1'b0, 1'b0, 1'b1, 61'h2B,  1};
        tbl[6] = '{1'b0, 61'h0,   1'b0, 1'b0, 1'b1, 61'h3C,  2};
        tbl[7] = '{1'b0, 61'h0,   1'b0, 1'b1, 1'b0, 61'h3C,  1};
        tbl[8] = '{1'b0, 61'h0,   1'b0, 1'b1, 1'b0, 61'h3C,  0};

        @(negedge clk);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_almfull_high", 64'(afu_alm), 64'(1'b1));
        idle(1'b0, 1'b0);
        chk("post_reset_almfull", 64'(afu_alm), 64'(1'b0));

        // Directed table: latency, ordering and counter behaviour.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].push, tbl[i].hdr, tbl[i].qa, tbl[i].rx, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 64'(qlp_v), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_hdr", i), 64'(qlp_hdr), 64'(tbl[i].eh));
            chk($sformatf("tbl%0d_out", i), 64'(outs), 64'(tbl[i].eo));
        end

        // Back-pressure: 12 pushes blocked, then drained with matched responses.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 61'(12'h100 + i), 1'b1, 1'b0, 1'b0);
            if (i == 10) chk("bp_alm_before", 64'(afu_alm), 64'(1'b0));
        end
        chk("bp_alm_after12", 64'(afu_alm), 64'(1'b1));
        chk("bp_no_valid", 64'(qlp_v), 64'(1'b0));
        for (int i = 0; i < 12; i++) begin
            idle(1'b0, 1'b1);
            chk($sformatf("bp_drain%0d", i), 64'({qlp_v, qlp_hdr}), 64'({1'b1, 61'(12'h100 + i)}));
        end
        idle(1'b0, 1'b0);
        chk("bp_drained", 64'(qlp_v), 64'(1'b0));

        // Overflow: 17 pushes blocked; the 17th is dropped.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 61'(12'h200 + i), 1'b1, 1'b0, 1'b0);
            if (i == 15) chk("ovf_not_yet", 64'(e_ovf), 64'(1'b0));
        end
        chk("ovf_set", 64'(e_ovf), 64'(1'b1));
        for (int i = 0; i < 16; i++) begin
            idle(1'b0, 1'b1);
            chk($sformatf("ovf_drain%0d", i), 64'(qlp_hdr), 64'(61'(12'h200 + i)));
        end
        idle(1'b0, 1'b0);
        chk("ovf_17th_absent", 64'(qlp_v), 64'(1'b0));

        // Outstanding limit of four.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        nv = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 6, 61'(12'h300 + i), 1'b0, 1'b0, 1'b0);
            if (qlp_v) nv++;
        end
        chk("lim_issued", 64'(nv), 64'(4));
        chk("lim_out", 64'(outs), 64'(4));
        idle(1'b0, 1'b1);
        chk("lim_5th", 64'({qlp_v, qlp_hdr}), 64'({1'b1, 61'h304}));
        chk("lim_out_same", 64'(outs), 64'(4));
        idle(1'b0, 1'b1);
        chk("lim_6th", 64'(qlp_hdr), 64'(61'h305));
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);
        chk("lim_out_zero", 64'(outs), 64'(0));

        // Underflow.
        idle(1'b0, 1'b1);
        chk("unf_set", 64'(e_unf), 64'(1'b1));
        chk("unf_out", 64'(outs), 64'(0));

        // Reset mid-stream: 5 queued, 2 issued, 1-cycle reset.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 61'(12'h400 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("mid_out2", 64'(outs), 64'(2));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("mid_alm_in_reset", 64'(afu_alm), 64'(1'b1));
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b0);
            if (i == 0) chk("mid_alm_after", 64'(afu_alm), 64'(1'b0));
            if (qlp_v) nv++;
        end
        chk("mid_no_valids", 64'(nv), 64'(0));
        chk("mid_out0", 64'(outs), 64'(0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic rx;
            rx = (m_out > 0) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            step($urandom_range(9) < 6, 61'({$urandom(), $urandom()}),
                 $urandom_range(3) == 0, rx, $urandom_range(99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cci_mpf_c0_rd_req_buffer.md
Name: cci_mpf_c0_rd_req_buffer

Overview:
- Channel-0 read-request staging buffer between AFU-side and QLP-side C0 read-request signals.
- Absorbs AFU read requests into a FIFO and forwards them to the QLP only when QLP C0TxAlmFull is low and the outstanding-read limit is not reached.
- Counts outstanding reads, retiring one per C0RxRdValid.
- Exports a registered almost-full to the AFU with fixed slack, so the AFU never sees QLP back-pressure directly.

Parameters:
- CCI_TX_HDR_WIDTH, 61, request header width.
- DEPTH, 16, FIFO entries; power of 2, at least 8.
- ALMFULL_SLACK, 4, requests the AFU may still issue after afu_C0TxAlmFull asserts; 1 to DEPTH-2.
- MAX_OUTSTANDING, 128, maximum reads issued to QLP and not yet answered.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- afu_C0TxHdr  in  CCI_TX_HDR_WIDTH  AFU read-request header.
- afu_C0TxRdValid  in  1  AFU read-request valid.
- afu_C0TxAlmFull  out  1  almost-full to AFU.
- qlp_C0TxHdr  out  CCI_TX_HDR_WIDTH  header to QLP.
- qlp_C0TxRdValid  out  1  read-request valid to QLP.
- qlp_C0TxAlmFull  in  1  QLP almost-full.
- qlp_C0RxRdValid  in  1  read response from QLP; retires one outstanding read.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding-read count.
- err_overflow  out  1  sticky: push while FIFO full.
- err_underflow  out  1  sticky: response while outstanding==0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FIFO empty, outstanding=0, qlp_C0TxRdValid=0, qlp_C0TxHdr=0, err_overflow=0, err_underflow=0.
- afu_C0TxAlmFull=1 while reset is high. It reflects occupancy on the first cycle after reset drops, i.e. 0.
- Push: afu_C0TxRdValid=1 writes afu_C0TxHdr at the tail that cycle, regardless of afu_C0TxAlmFull.
  - If the FIFO is full and no pop occurs the same cycle, the request is dropped and err_overflow sets.
  - Push on full with a simultaneous pop is legal: no error, occupancy unchanged.
- Pop condition, evaluated on registered state:
  - FIFO non-empty, and
  - qlp_C0TxAlmFull=0, and
  - (outstanding < MAX_OUTSTANDING, or a qlp_C0RxRdValid arrives this cycle).
- On pop:
  - head entry moves to qlp_C0TxHdr/qlp_C0TxRdValid registers; valid is high the next cycle for exactly one cycle per request;
  - outstanding increments on the same edge the valid register loads.
  - With no pop, qlp_C0TxRdValid=0 and qlp_C0TxHdr holds its last value.
- Ordering: strict FIFO. At most one pop per cycle.
- Latency: request presented at cycle N into an empty FIFO with no back-pressure gives qlp_C0TxRdValid=1 at N+2. No bypass.
- Throughput: 1 request/cycle sustained when unthrottled.
- Almost-full: afu_C0TxAlmFull is registered, = (next occupancy >= DEPTH-ALMFULL_SLACK). next occupancy = occupancy + push - pop.
  - An AFU that stops within ALMFULL_SLACK requests of seeing it never overflows.
- Outstanding counter:
  - issue alone: +1; response alone: -1; both in the same cycle: unchanged.
  - Response with outstanding=0 and no same-cycle issue: counter stays 0 and err_underflow sets.
  - Saturates at MAX_OUTSTANDING, which the pop rule already guarantees.
- QLP almost-full: qlp_C0TxAlmFull sampled combinationally into the pop decision. A request already in the output register when qlp_C0TxAlmFull rises is still delivered; this relies on QLP slack.
- Reset mid-operation: FIFO contents and in-flight counts are discarded; all outputs return to reset values on the next edge.
- Error flags clear only on reset.

Test Plan:
- Reset then a single request: hdr=0x1A5, RdValid at cycle 10 -> qlp_C0TxRdValid=1 with hdr 0x1A5 at cycle 12 only; outstanding=1 from cycle 12. qlp_C0RxRdValid at cycle 20 -> outstanding=0 at cycle 21.
- Back-pressure: hold qlp_C0TxAlmFull=1, push 12 requests -> afu_C0TxAlmFull=1 visible after the 12th push (DEPTH=16, slack 4), no qlp valid. Release -> 12 valids on consecutive cycles in push order.
- Overflow: push 17 requests with QLP blocked -> err_overflow=1 after the 17th; the first 16 are later delivered intact; the 17th never appears.
- Outstanding limit (MAX_OUTSTANDING=4): push 6 with no responses -> exactly 4 issued, outstanding=4. One response -> the 5th issues the following cycle. Response and issue in the same cycle -> outstanding stays 4.
- Underflow: qlp_C0RxRdValid with outstanding=0 -> err_underflow=1; outstanding remains 0.
- Reset mid-stream: 5 requests queued, 2 issued, reset pulsed 1 cycle -> outstanding=0, no further qlp valids, afu_C0TxAlmFull=1 during reset and 0 on the cycle after.
